// File: rtl/alu_dec.sv
// rtl/alu_dec.sv - registered RV32I ALU control decoder with illegal-encoding flag
module alu_dec (
  input  logic       clk,
  input  logic       reset,
  input  logic       opb5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic [1:0] ALUOp,
  output logic [2:0] ALUControl,
  output logic       illegal
);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic [2:0] ctrl_d, ctrl_q;
  logic       illegal_d, illegal_q;

  // Pure combinational decode; unsupported encodings fall back to ADD so the ALU never sees an undefined select
  always_comb begin
    ctrl_d    = ALU_ADD;
    illegal_d = 1'b0;
    unique case (ALUOp)
      2'b00: ctrl_d = ALU_ADD;
      2'b01: ctrl_d = ALU_SUB;
      2'b10: begin
        unique case (funct3)
          3'b000: ctrl_d = (opb5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010: ctrl_d = ALU_SLT;
          3'b100: ctrl_d = ALU_XOR;
          3'b110: ctrl_d = ALU_OR;
          3'b111: ctrl_d = ALU_AND;
          default: begin
            ctrl_d    = ALU_ADD;
            illegal_d = 1'b1;
          end
        endcase
      end
      default: begin
        ctrl_d    = ALU_ADD;
        illegal_d = 1'b1;
      end
    endcase
  end

  // Output register; reset discards whatever decode is pending at that edge
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q    <= ALU_ADD;
      illegal_q <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
    end
  end

  assign ALUControl = ctrl_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_alu_dec.sv
// tb/tb_alu_dec.sv - table-driven and random-stream bench for alu_dec
module tb_alu_dec;

  logic       clk = 1'b0;
  logic       reset;
  logic       opb5;
  logic [2:0] funct3;
  logic       funct7b5;
  logic [1:0] ALUOp;
  logic [2:0] ALUControl;
  logic       illegal;

  int passed = 0;
  int total  = 0;

  alu_dec dut (
    .clk        (clk),
    .reset      (reset),
    .opb5       (opb5),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .ALUOp      (ALUOp),
    .ALUControl (ALUControl),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [1:0] aluop;
    logic [2:0] f3;
    logic       b5;
    logic       f7;
    logic [2:0] exp_ctrl;
    logic       exp_ill;
  } vec_t;

  vec_t vecs[$];

  // Reference decode written as an if-chain over the operation table
  function automatic logic [3:0] ref_model(input logic [1:0] op, input logic [2:0] f3,
                                           input logic b5, input logic f7);
    logic [2:0] c;
    logic       il;
    c  = 3'd0;
    il = 1'b0;
    if (op == 2'd0)       c = 3'd0;
    else if (op == 2'd1)  c = 3'd1;
    else if (op == 2'd3)  il = 1'b1;
    else begin
      if (f3 == 3'd0)      c = (b5 & f7) ? 3'd1 : 3'd0;
      else if (f3 == 3'd2) c = 3'd5;
      else if (f3 == 3'd4) c = 3'd4;
      else if (f3 == 3'd6) c = 3'd3;
      else if (f3 == 3'd7) c = 3'd2;
      else                 il = 1'b1;
    end
    return {il, c};
  endfunction

  task automatic check(input string name, input logic [2:0] exp_c, input logic exp_i);
    total++;
    if (ALUControl === exp_c && illegal === exp_i) passed++;
    else $display("FAIL %s: got ctrl=%b ill=%b, expected ctrl=%b ill=%b",
                  name, ALUControl, illegal, exp_c, exp_i);
  endtask

  task automatic apply(input logic rst, input logic [1:0] op, input logic [2:0] f3,
                       input logic b5, input logic f7);
    reset = rst; ALUOp = op; funct3 = f3; opb5 = b5; funct7b5 = f7;
  endtask

  // Advance one edge and settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] e;
    logic       r;
    vecs.push_back('{"addsub_r_sub", 2'b10, 3'b000, 1'b1, 1'b1, 3'b001, 1'b0});
    vecs.push_back('{"addsub_r_add", 2'b10, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0});
    vecs.push_back('{"addsub_i_add", 2'b10, 3'b000, 1'b0, 1'b1, 3'b000, 1'b0});
    vecs.push_back('{"slt",          2'b10, 3'b010, 1'b1, 1'b0, 3'b101, 1'b0});
    vecs.push_back('{"xor",          2'b10, 3'b100, 1'b0, 1'b0, 3'b100, 1'b0});
    vecs.push_back('{"or",           2'b10, 3'b110, 1'b1, 1'b1, 3'b011, 1'b0});
    vecs.push_back('{"and",          2'b10, 3'b111, 1'b0, 1'b1, 3'b010, 1'b0});
    vecs.push_back('{"ill_sll",      2'b10, 3'b001, 1'b1, 1'b0, 3'b000, 1'b1});
    vecs.push_back('{"ill_sltu",     2'b10, 3'b011, 1'b0, 1'b0, 3'b000, 1'b1});
    vecs.push_back('{"ill_sr",       2'b10, 3'b101, 1'b1, 1'b1, 3'b000, 1'b1});
    vecs.push_back('{"ill_op11",     2'b11, 3'b010, 1'b0, 1'b0, 3'b000, 1'b1});
    vecs.push_back('{"legal_clears", 2'b10, 3'b100, 1'b1, 1'b0, 3'b100, 1'b0});
    vecs.push_back('{"ill_op11_b",   2'b11, 3'b000, 1'b1, 1'b1, 3'b000, 1'b1});
    vecs.push_back('{"op00_after",   2'b00, 3'b111, 1'b1, 1'b1, 3'b000, 1'b0});

    // Reset held three edges with random inputs
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 2'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
      tick();
      check("reset_hold", 3'b000, 1'b0);
    end
    // First edge after release decodes immediately
    apply(1'b0, 2'b01, 3'($urandom), 1'($urandom), 1'($urandom));
    tick();
    check("reset_release_sub", 3'b001, 1'b0);

    // Fixed classes over every funct/opb5 combination
    for (int k = 0; k < 32; k++) begin
      apply(1'b0, 2'b00, k[2:0], k[3], k[4]);
      tick();
      check("class_add", 3'b000, 1'b0);
      apply(1'b0, 2'b01, k[2:0], k[3], k[4]);
      tick();
      check("class_sub", 3'b001, 1'b0);
    end

    // Directed table, one result per edge
    foreach (vecs[i]) begin
      apply(1'b0, vecs[i].aluop, vecs[i].f3, vecs[i].b5, vecs[i].f7);
      tick();
      check(vecs[i].name, vecs[i].exp_ctrl, vecs[i].exp_ill);
    end

    // Input changes between edges must not disturb the outputs
    apply(1'b0, 2'b10, 3'b010, 1'b0, 1'b0);
    tick();
    check("pre_glitch_slt", 3'b101, 1'b0);
    apply(1'b0, 2'b11, 3'b001, 1'b1, 1'b1);
    @(negedge clk);
    check("between_edges_hold", 3'b101, 1'b0);
    tick();
    check("after_glitch_ill", 3'b000, 1'b1);

    // Mid-stream reset discards the pending decode, then resumes at once
    apply(1'b1, 2'b10, 3'b111, 1'b0, 1'b0);
    tick();
    check("midstream_reset", 3'b000, 1'b0);
    apply(1'b0, 2'b10, 3'b111, 1'b0, 1'b0);
    tick();
    check("post_reset_and", 3'b010, 1'b0);

    // Random stream against the reference model, with sporadic and one forced reset
    for (int c = 0; c < 1000; c++) begin
      r = ($urandom_range(0, 29) == 0) || (c == 500);
      apply(r, 2'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
      e = r ? 4'b0000 : ref_model(ALUOp, funct3, opb5, funct7b5);
      tick();
      check("random", e[2:0], e[3]);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_dec.md
# alu_dec

ALU control decoder for the single-issue RV32I core. It maps the main decoder's 2-bit `ALUOp` plus instruction fields (`funct3`, `funct7[5]`, `op[5]`) to the 3-bit `ALUControl` operation select consumed by the ALU. The output is registered: one clock, synchronous active-high reset. An `illegal` flag marks encodings the ALU does not implement.

## Interface
- No parameters.
- `clk`  input  1  rising-edge clock; all state updates on this edge.
- `reset`  input  1  synchronous, active-high; clears outputs at the next rising edge.
- `opb5`  input  1  bit 5 of instruction opcode (1 = R-type, 0 = I-type ALU).
- `funct3`  input  3  instruction funct3 field.
- `funct7b5`  input  1  bit 5 of instruction funct7 field.
- `ALUOp`  input  2  class from main decoder: 00 add, 01 subtract, 10 decode from funct fields, 11 reserved.
- `ALUControl`  output  3  registered ALU operation select.
- `illegal`  output  1  registered; 1 when the sampled input combination is unsupported.

## Operation
- ALUControl encoding: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT; 110 and 111 are never produced.
- ALUOp = 00 (loads, stores, address calc): ADD, illegal=0; funct fields ignored.
- ALUOp = 01 (branches): SUB, illegal=0; funct fields ignored.
- ALUOp = 10 (R-type / I-type ALU), by funct3:
  - 000: SUB if opb5=1 and funct7b5=1; otherwise ADD. I-type ADDI with funct7b5=1 (immediate bit) decodes to ADD.
  - 010: SLT.
  - 100: XOR.
  - 110: OR.
  - 111: AND.
  - 001, 011, 101 (shifts, SLTU): ADD with illegal=1.
- ALUOp = 11: ADD with illegal=1.
- Illegal encodings never produce X; ALUControl is always one of the defined codes.
- Decode is a pure function of the four inputs; only the outputs hold state.

## Timing
- Inputs are sampled on each rising `clk` edge. The decoded result appears on `ALUControl`/`illegal` after that edge. Latency is 1 cycle, with a new result every cycle.
- `reset`=1 at a rising edge forces `ALUControl`=000 and `illegal`=0. This overrides any input values at that edge.
- Reset held for multiple cycles keeps outputs at the reset value. Outputs are undefined only before the first clock edge.
- On the first edge with `reset`=0, the decode of the inputs present at that edge is registered. There is no extra wait cycle after reset.
- Reset asserted mid-stream takes effect at the next edge, and the pending decode is discarded.
- Input changes between edges have no effect on outputs.

## Test plan
- Reset: hold `reset`=1 for 3 edges with random inputs -> `ALUControl`=000, `illegal`=0 after each edge. Release with ALUOp=01 -> SUB (001) after the next edge.
- Fixed classes: ALUOp=00 with random funct fields -> 000, illegal 0. ALUOp=01 with random funct fields -> 001, illegal 0. Both hold for all 32 funct/opb5 combinations.
- ADD/SUB split with ALUOp=10, funct3=000:
  - opb5=1, funct7b5=1 -> 001.
  - opb5=1, funct7b5=0 -> 000.
  - opb5=0, funct7b5=1 -> 000.
- Logic ops with ALUOp=10: funct3 010/100/110/111 -> 101/100/011/010 respectively, illegal 0, each one cycle after being applied.
- Illegal encodings:
  - ALUOp=10 with funct3 001/011/101 -> 000 with illegal=1.
  - ALUOp=11 -> 000 with illegal=1.
  - Following legal input clears illegal on the next edge.
- Random stream: 1000 cycles of random inputs with a sporadic reset, checked against a reference model delayed one cycle. Includes reset asserted mid-stream.
